// File: rtl/gate_sweep_ctrl.sv
// Exhaustive 3-input truth-table sweep sequencer for a combinational gate under test.
// Drives a/b/c, waits SETTLE_CYCLES, checks synchronized dut_y against the selected function.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  logic [2:0] vec_r;
  logic [3:0] cnt_r;
  logic [1:0] mode_r;
  logic       sync1_r;
  logic       y_s;
  logic       mismatch_s;
  logic [3:0] err_nxt_s;

  function automatic logic expected_fn(input logic [1:0] m, input logic [2:0] v);
    logic r;
    case (m)
      2'b00:   r = ~(&v);
      2'b01:   r = ~(|v);
      2'b10:   r = &v;
      2'b11:   r = ^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous gate output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      y_s     <= 1'b0;
    end else begin
      sync1_r <= dut_y;
      y_s     <= sync1_r;
    end
  end

  // Mismatch detection and saturating error count for the current check
  always_comb begin
    mismatch_s = 1'b0;
    err_nxt_s  = err_count;
    if (state_r == ST_CHECK) begin
      mismatch_s = (y_s != expected_fn(mode_r, vec_r));
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (err_count != 4'd8)) begin
      err_nxt_s = err_count + 4'd1;
    end else begin
      err_nxt_s = err_count;
    end
  end

  // Sweep FSM with registered outputs; abort overrides everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      vec_r      <= 3'd0;
      cnt_r      <= 4'd0;
      mode_r     <= 2'b00;
      {a, b, c}  <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fail_valid <= 1'b0;
    end else if (abort) begin
      // Result registers are deliberately kept for post-abort debug
      state_r   <= ST_IDLE;
      vec_r     <= 3'd0;
      cnt_r     <= 4'd0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_SETTLE;
            vec_r      <= 3'd0;
            cnt_r      <= 4'd0;
            mode_r     <= mode;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            first_fail <= 3'd0;
            fail_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_CHECK: begin
          err_count <= err_nxt_s;
          if (mismatch_s && !fail_valid) begin
            first_fail <= vec_r;
            fail_valid <= 1'b1;
          end else begin
            fail_valid <= fail_valid;
          end
          if (vec_r == 3'd7) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_nxt_s == 4'd0);
          end else begin
            state_r   <= ST_SETTLE;
            vec_r     <= vec_r + 3'd1;
            {a, b, c} <= vec_r + 3'd1;
            cnt_r     <= 4'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table-driven sweeps, abort/reset sequences,
// and randomized gate truth tables checked against a truth-table difference model.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort;
  logic [1:0] mode;
  logic [7:0] gate_tt;
  logic       dut_y, dut_y3;
  logic       a, b, c, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       a3, b3, c3, busy3, done3, pass3, fail_valid3;
  logic [3:0] err_count3;
  logic [2:0] first_fail3;

  // Gate under test modelled as an arbitrary 8-entry truth table indexed by {a,b,c}
  assign dut_y  = gate_tt[{a, b, c}];
  assign dut_y3 = gate_tt[{a3, b3, c3}];

  gate_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .dut_y(dut_y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .dut_y(dut_y3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_fail(first_fail3), .fail_valid(fail_valid3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] tt;
    logic [1:0] mode;
    int         err;
    int         first;
    logic       fv;
    logic       pass;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: expected truth table from the function definitions, diffed against the gate
  task automatic ref_model(input logic [7:0] tt, input logic [1:0] m,
                           output int err, output int first, output logic fv, output logic ps);
    logic [7:0] exp_tt;
    logic [7:0] diff;
    logic [2:0] v3;
    logic x, y, z;
    exp_tt = 8'h00;
    for (int v = 0; v < 8; v++) begin
      v3 = 3'(v);
      x = v3[2]; y = v3[1]; z = v3[0];
      case (m)
        2'b00:   exp_tt[v] = ~(x & y & z);
        2'b01:   exp_tt[v] = ~(x | y | z);
        2'b10:   exp_tt[v] = x & y & z;
        default: exp_tt[v] = x ^ y ^ z;
      endcase
    end
    diff  = tt ^ exp_tt;
    err   = $countones(diff);
    fv    = (diff != 8'h00);
    ps    = (diff == 8'h00);
    first = 0;
    for (int v = 7; v >= 0; v--) begin
      if (diff[v]) first = v;
    end
  endtask

  task automatic run_sweep(input logic [7:0] tt, input logic [1:0] m, input int exp_err,
                           input int exp_first, input logic exp_fv, input logic exp_pass,
                           input bit noise, input bit check3, input string tag);
    int k, k3;
    bit seq_bad;
    gate_tt = tt;
    mode    = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0; k3 = -1; seq_bad = 1'b0;
    while (!done && k < 200) begin
      if (k < 40 && ({a, b, c} !== 3'(k / 5) || busy !== 1'b1)) seq_bad = 1'b1;
      if (check3 && k3 < 0 && done3) k3 = k;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, " cycles_to_done"}, k, 40);
    check({tag, " abc_sequence_ok"}, {31'd0, seq_bad}, 0);
    check({tag, " abc_in_done"}, {a, b, c}, 3'b111);
    check({tag, " busy_in_done"}, busy, 1'b0);
    check({tag, " err_count"}, err_count, exp_err);
    check({tag, " fail_valid"}, fail_valid, exp_fv);
    check({tag, " pass"}, pass, exp_pass);
    if (exp_fv) check({tag, " first_fail"}, first_fail, exp_first);
    if (check3) begin
      check({tag, " settle3_cycles_to_done"}, k3, 32);
      check({tag, " settle3_pass"}, pass3, exp_pass);
    end
  endtask

  initial begin
    int   r_err, r_first;
    logic r_fv, r_pass;
    logic [7:0] r_tt;
    logic [1:0] r_mode;

    tbl[0] = '{8'h7F, 2'b00, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 2'b00, 1, 7, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 2'b00, 7, 0, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 2'b01, 6, 1, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 2'b10, 0, 0, 1'b0, 1'b1};
    tbl[5] = '{8'h96, 2'b11, 0, 0, 1'b0, 1'b1};
    tbl[6] = '{8'h7F, 2'b11, 5, 0, 1'b1, 1'b0};
    tbl[7] = '{8'h69, 2'b11, 8, 0, 1'b1, 1'b0};

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; gate_tt = 8'h7F;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset abc", {a, b, c}, 3'b000);
    check("reset err_count", err_count, 0);
    check("reset fail_valid", fail_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].tt, tbl[i].mode, tbl[i].err, tbl[i].first, tbl[i].fv,
                tbl[i].pass, 1'b0, (i == 0), $sformatf("tbl%0d", i));
    end

    repeat (3) @(negedge clk);
    check("done held", done, 1'b1);

    // Abort at cycle 12 after two failing checks; results must survive
    gate_tt = 8'h00; mode = 2'b00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort abc", {a, b, c}, 3'b000);
    check("abort err kept", err_count, 2);
    check("abort fail_valid kept", fail_valid, 1'b1);
    check("abort first_fail kept", first_fail, 0);
    repeat (3) @(negedge clk);
    check("abort stays idle", busy, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("abort beats start busy", busy, 1'b0);
    check("abort beats start err", err_count, 2);

    // Asynchronous reset mid-sweep
    gate_tt = 8'h00; mode = 2'b00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset abc", {a, b, c}, 3'b000);
    check("async reset err", err_count, 0);
    check("async reset fail_valid", fail_valid, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run_sweep(8'h7F, 2'b00, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, "post_reset");

    // Randomized gates, modes, and start/mode noise while busy
    for (int i = 0; i < 20; i++) begin
      r_tt   = 8'($urandom);
      r_mode = 2'($urandom);
      ref_model(r_tt, r_mode, r_err, r_first, r_fv, r_pass);
      run_sweep(r_tt, r_mode, r_err, r_first, r_fv, r_pass, 1'b1, 1'b0,
                $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that drives an exhaustive 3-input truth-table sweep into a combinational gate under test (NAND3 and its relatives) on the lab FPGA.
- Applies each of the 8 input vectors and waits a programmable settle time.
- Samples the gate output through a 2-flop synchronizer and compares it with the expected function.
- Reports error count, first failing vector and pass/fail.
- Replaces the manual per-vector stepping of the gate testbenches with an on-chip, self-checking controller.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before its check; legal range 3..15 so it covers the 2-flop synchronizer latency.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled in IDLE or DONE only
abort  input  1  synchronous abort; returns to IDLE
mode  input  2  expected function: 00 NAND3, 01 NOR3, 10 AND3, 11 XOR3; latched at start
dut_y  input  1  gate output, asynchronous to clk
a  output  1  gate input A (vector bit 2)
b  output  1  gate input B (vector bit 1)
c  output  1  gate input C (vector bit 0)
busy  output  1  high in SETTLE or CHECK
done  output  1  high in DONE; held until start, abort or reset
pass  output  1  done and err_count == 0
err_count  output  4  number of mismatching vectors, 0..8
first_fail  output  3  first mismatching vector; valid only when fail_valid
fail_valid  output  1  at least one mismatch recorded this sweep

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; a, b, c, busy, done, pass, fail_valid all 0; err_count = 0; first_fail = 0; vec = 0; settle counter = 0; synchronizer flops = 0.
- dut_y passes through two flops; the comparison uses only the second flop (y_s).
- IDLE:
  - start=1 → SETTLE, with vec <= 0, {a,b,c} <= 000, cnt <= 0.
  - On the same edge: mode latched; err_count, fail_valid and first_fail cleared.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1 → CHECK.
- CHECK (one cycle):
  - If y_s != expected(mode_latched, vec): err_count <= err_count+1.
  - If that mismatch is the first of the sweep: first_fail <= vec and fail_valid <= 1.
  - If vec == 7 → DONE.
  - Otherwise vec <= vec+1, {a,b,c} <= vec+1, cnt <= 0, → SETTLE.
- DONE:
  - done = 1; pass = (err_count == 0).
  - {a,b,c} hold 111.
  - start=1 → new sweep, exactly as from IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE is entered 8*(SETTLE_CYCLES+1) cycles after the edge that sampled start; 40 cycles at the default.
  - {a,b,c} are registered and change only on the start edge or on CHECK→SETTLE edges.
- Expected functions:
  - NAND3 = ~(a&b&c)
  - NOR3 = ~(a|b|c)
  - AND3 = a&b&c
  - XOR3 = a^b^c
- start while busy: ignored.
- mode changes while busy: ignored; the latched value is used.
- abort (any state, priority over start):
  - → IDLE; a, b, c, busy, done, pass = 0.
  - err_count, first_fail and fail_valid keep their values for debug until the next start.
- start and abort high together: abort wins, state IDLE.
- rst_n asserted mid-sweep: immediate return to reset values; no partial results retained.
- err_count never exceeds 8; no wrap.

Test Plan:
1. Ideal NAND3 model on dut_y, mode=00, default parameter, start pulse → busy for 40 cycles, then done=1, pass=1, err_count=0, fail_valid=0; a,b,c step 000..111, each vector held 5 cycles.
2. dut_y stuck at 1, mode=00 → err_count=1, first_fail=7, fail_valid=1, pass=0.
3. dut_y stuck at 0, mode=00 → err_count=7, first_fail=0, pass=0.
4. Ideal NAND3 model, mode=01 (NOR3) → err_count=6, first_fail=1; vectors 0 and 7 match.
5. abort at cycle 12 of a sweep → next cycle: IDLE, busy=0, done=0, abc=000. Also: start pulsed while busy in a separate run → ignored, DONE still at cycle 40.
6. rst_n low for 2 cycles mid-sweep, asynchronous to clk → all outputs at reset values immediately; a fresh start then completes in 40 cycles with correct results. Also: a run with SETTLE_CYCLES=3 reaches DONE in 32 cycles.
